// File: rtl/decode_queue_if.sv
// Handshake bundle between fetch, the decode queue and dispatch.
// Widths are parameters so this file has no package dependency.
interface decode_queue_if #(
  parameter int XLEN = 32,
  parameter int SI_W = 86
);
  logic            fetch_valid_i;
  logic            fetch_ready_o;
  logic [XLEN-1:0] fetch_pc_i;
  logic [31:0]     fetch_instr_i;
  logic            dec_valid_o;
  logic            dec_ready_i;
  logic [SI_W-1:0] dec_si_o;

  modport master (
    output fetch_valid_i, fetch_pc_i, fetch_instr_i, dec_ready_i,
    input  fetch_ready_o, dec_valid_o, dec_si_o
  );

  modport slave (
    input  fetch_valid_i, fetch_pc_i, fetch_instr_i, dec_ready_i,
    output fetch_ready_o, dec_valid_o, dec_si_o
  );
endinterface

// File: rtl/decode_queue.sv
// Front-end decode stage: RV32I static decoder feeding a DEPTH-entry circular
// queue toward dispatch, with backpressure and synchronous flush.
package C;
  localparam int XLEN = 32;

  typedef enum logic [5:0] {
    I_ILLEGAL, I_LUI, I_AUIPC, I_JAL, I_JALR,
    I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
    I_LB, I_LH, I_LW, I_LBU, I_LHU,
    I_SB, I_SH, I_SW,
    I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI,
    I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND,
    I_FENCE, I_ECALL, I_EBREAK
  } op_e;

  typedef struct packed {
    logic            valid;
    op_e             op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic [XLEN-1:0] pc;
  } si_t;
endpackage

module static_decoder
  import C::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output si_t             si_o
);
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  op_e         op;
  logic [31:0] imm;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign imm_sh = {27'b0, instr_i[24:20]};

  // Any encoding that does not land on a known op stays I_ILLEGAL.
  always_comb begin
    op  = I_ILLEGAL;
    imm = '0;
    case (opcode)
      7'h37: begin op = I_LUI;   imm = imm_u; end
      7'h17: begin op = I_AUIPC; imm = imm_u; end
      7'h6F: begin op = I_JAL;   imm = imm_j; end
      7'h67: begin
        imm = imm_i;
        if (f3 == 3'b000) op = I_JALR;
      end
      7'h63: begin
        imm = imm_b;
        case (f3)
          3'b000:  op = I_BEQ;
          3'b001:  op = I_BNE;
          3'b100:  op = I_BLT;
          3'b101:  op = I_BGE;
          3'b110:  op = I_BLTU;
          3'b111:  op = I_BGEU;
          default: op = I_ILLEGAL;
        endcase
      end
      7'h03: begin
        imm = imm_i;
        case (f3)
          3'b000:  op = I_LB;
          3'b001:  op = I_LH;
          3'b010:  op = I_LW;
          3'b100:  op = I_LBU;
          3'b101:  op = I_LHU;
          default: op = I_ILLEGAL;
        endcase
      end
      7'h23: begin
        imm = imm_s;
        case (f3)
          3'b000:  op = I_SB;
          3'b001:  op = I_SH;
          3'b010:  op = I_SW;
          default: op = I_ILLEGAL;
        endcase
      end
      7'h13: begin
        imm = imm_i;
        case (f3)
          3'b000: op = I_ADDI;
          3'b010: op = I_SLTI;
          3'b011: op = I_SLTIU;
          3'b100: op = I_XORI;
          3'b110: op = I_ORI;
          3'b111: op = I_ANDI;
          3'b001: begin
            imm = imm_sh;
            if (f7 == 7'b0000000) op = I_SLLI;
          end
          default: begin
            imm = imm_sh;
            if (f7 == 7'b0000000)      op = I_SRLI;
            else if (f7 == 7'b0100000) op = I_SRAI;
          end
        endcase
      end
      7'h33: begin
        case ({f7, f3})
          10'b0000000_000: op = I_ADD;
          10'b0100000_000: op = I_SUB;
          10'b0000000_001: op = I_SLL;
          10'b0000000_010: op = I_SLT;
          10'b0000000_011: op = I_SLTU;
          10'b0000000_100: op = I_XOR;
          10'b0000000_101: op = I_SRL;
          10'b0100000_101: op = I_SRA;
          10'b0000000_110: op = I_OR;
          10'b0000000_111: op = I_AND;
          default:         op = I_ILLEGAL;
        endcase
      end
      7'h0F: if (f3 == 3'b000) op = I_FENCE;
      7'h73: begin
        if (instr_i == 32'h0000_0073)      op = I_ECALL;
        else if (instr_i == 32'h0010_0073) op = I_EBREAK;
      end
      default: op = I_ILLEGAL;
    endcase
  end

  always_comb begin
    si_o       = '0;
    si_o.op    = op;
    si_o.valid = (op != I_ILLEGAL);
    si_o.rd    = instr_i[11:7];
    si_o.rs1   = instr_i[19:15];
    si_o.rs2   = instr_i[24:20];
    si_o.imm   = imm;
    si_o.pc    = pc_i;
  end
endmodule

module decode_queue
  import C::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  decode_queue_if.slave    bus,
  output logic [CNT_W-1:0] count_o,
  output logic             illegal_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  si_t              mem [DEPTH];
  si_t              decoded;
  si_t              head_si;
  logic             fetch_ready, dec_valid, enq, deq;

  static_decoder decoder (
    .pc_i    (bus.fetch_pc_i),
    .instr_i (bus.fetch_instr_i),
    .si_o    (decoded)
  );

  // Ready depends only on registered count, never on dispatch's ready.
  assign fetch_ready = !rst_i && !flush_i && (count < CNT_W'(DEPTH));
  assign dec_valid   = (count != '0);
  assign enq         = bus.fetch_valid_i && fetch_ready && !flush_i;
  assign deq         = dec_valid && bus.dec_ready_i && !flush_i;
  assign head_si     = mem[head];

  assign bus.fetch_ready_o = fetch_ready;
  assign bus.dec_valid_o   = dec_valid;
  assign bus.dec_si_o      = head_si;
  assign count_o           = count;
  assign illegal_o         = dec_valid && !head_si.valid;

  // Pointer and occupancy state; flush wins over any handshake that cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; count alone says what is live.
  always_ff @(posedge clk_i) begin
    if (enq) mem[tail] <= decoded;
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    count <= CNT_W'(DEPTH));

  a_ptr_consistent: assert property (@(posedge clk_i) disable iff (rst_i)
    PTR_W'(tail - head) == count[PTR_W-1:0]);

  a_head_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (dec_valid && !bus.dec_ready_i && !flush_i) |=> $stable(head_si));
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: reset, single decode, fill/backpressure,
// steady streaming, illegal encodings, flush and mid-stream reset.
module tb_decode_queue;
  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  logic       illegal;
  C::si_t     si;
  int         checks;
  int         failures;

  decode_queue_if #(.XLEN(C::XLEN), .SI_W($bits(C::si_t))) bus ();

  decode_queue #(.DEPTH(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (flush),
    .bus       (bus.slave),
    .count_o   (count),
    .illegal_o (illegal)
  );

  assign si = bus.dec_si_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] addi(input int rd, input int imm);
    logic [11:0] i12;
    logic [4:0]  r5;
    i12 = 12'(imm);
    r5  = 5'(rd);
    return {i12, 5'd0, 3'b000, r5, 7'h13};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic enq_one(input logic [31:0] pc, input logic [31:0] instr);
    bus.fetch_valid_i = 1'b1;
    bus.fetch_pc_i    = pc;
    bus.fetch_instr_i = instr;
    step();
    bus.fetch_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.fetch_valid_i = 1'b0;
    bus.fetch_pc_i    = '0;
    bus.fetch_instr_i = '0;
    bus.dec_ready_i   = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    checks++; if (bus.dec_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_dec_valid got=%b exp=0", bus.dec_valid_o); end
    checks++; if (bus.fetch_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_fetch_ready got=%b exp=0", bus.fetch_ready_o); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("[TB] FAIL reset_illegal got=%b exp=0", illegal); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.fetch_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready got=%b exp=1", bus.fetch_ready_o); end
  endtask

  task automatic test_single();
    enq_one(32'h8000_0000, 32'h0050_0093);
    checks++; if (bus.dec_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL single_valid got=%b exp=1", bus.dec_valid_o); end
    checks++; if (si.op !== C::I_ADDI) begin failures++; $display("[TB] FAIL single_op got=%0d exp=%0d", si.op, C::I_ADDI); end
    checks++; if (si.rd !== 5'd1) begin failures++; $display("[TB] FAIL single_rd got=%0d exp=1", si.rd); end
    checks++; if (si.rs1 !== 5'd0) begin failures++; $display("[TB] FAIL single_rs1 got=%0d exp=0", si.rs1); end
    checks++; if (si.imm !== 32'd5) begin failures++; $display("[TB] FAIL single_imm got=%h exp=5", si.imm); end
    checks++; if (si.pc !== 32'h8000_0000) begin failures++; $display("[TB] FAIL single_pc got=%h exp=80000000", si.pc); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("[TB] FAIL single_illegal got=%b exp=0", illegal); end
    checks++; if (count !== 3'd1) begin failures++; $display("[TB] FAIL single_count got=%0d exp=1", count); end
    bus.dec_ready_i = 1'b1;
    step();
    bus.dec_ready_i = 1'b0;
    checks++; if (bus.dec_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL single_drain got=%b exp=0", bus.dec_valid_o); end
  endtask

  task automatic test_fill();
    logic [31:0] pcs [5];
    int          exp_cnt [5];
    exp_cnt = '{4, 3, 3, 2, 1};
    for (int i = 0; i < 5; i++) pcs[i] = 32'h1000 + 32'(4 * i);
    bus.dec_ready_i   = 1'b0;
    bus.fetch_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.fetch_pc_i    = pcs[i];
      bus.fetch_instr_i = addi(i + 1, i);
      step();
    end
    bus.fetch_pc_i    = pcs[4];
    bus.fetch_instr_i = addi(5, 4);
    #1;
    checks++; if (count !== 3'd4) begin failures++; $display("[TB] FAIL fill_count got=%0d exp=4", count); end
    checks++; if (bus.fetch_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL fill_ready got=%b exp=0", bus.fetch_ready_o); end
    step();
    checks++; if (count !== 3'd4) begin failures++; $display("[TB] FAIL fill_held got=%0d exp=4", count); end
    bus.dec_ready_i = 1'b1;
    for (int j = 0; j < 5; j++) begin
      checks++; if (bus.dec_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL fill_out_valid[%0d] got=%b exp=1", j, bus.dec_valid_o); end
      checks++; if (si.pc !== pcs[j]) begin failures++; $display("[TB] FAIL fill_out_pc[%0d] got=%h exp=%h", j, si.pc, pcs[j]); end
      checks++; if (si.rd !== 5'(j + 1)) begin failures++; $display("[TB] FAIL fill_out_rd[%0d] got=%0d exp=%0d", j, si.rd, j + 1); end
      checks++; if (count !== 3'(exp_cnt[j])) begin failures++; $display("[TB] FAIL fill_out_count[%0d] got=%0d exp=%0d", j, count, exp_cnt[j]); end
      if (j == 1) begin
        checks++; if (bus.fetch_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL fill_reopen got=%b exp=1", bus.fetch_ready_o); end
      end
      if (j == 2) bus.fetch_valid_i = 1'b0;
      step();
    end
    bus.dec_ready_i = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL fill_empty got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    logic [31:0] pc;
    bus.dec_ready_i = 1'b0;
    enq_one(32'h2000, addi(1, 1));
    exp_q.push_back(32'h2000);
    bus.dec_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      pc = 32'h2004 + 32'(4 * k);
      bus.fetch_valid_i = 1'b1;
      bus.fetch_pc_i    = pc;
      bus.fetch_instr_i = addi(2, k);
      checks++; if (count !== 3'd1) begin failures++; $display("[TB] FAIL steady_count[%0d] got=%0d exp=1", k, count); end
      checks++; if (si.pc !== exp_q[0]) begin failures++; $display("[TB] FAIL steady_pc[%0d] got=%h exp=%h", k, si.pc, exp_q[0]); end
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(pc);
    end
    bus.fetch_valid_i = 1'b0;
    checks++; if (si.pc !== exp_q[0]) begin failures++; $display("[TB] FAIL steady_last_pc got=%h exp=%h", si.pc, exp_q[0]); end
    step();
    bus.dec_ready_i = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL steady_empty got=%0d exp=0", count); end
  endtask

  task automatic test_illegal();
    bus.dec_ready_i = 1'b0;
    enq_one(32'h3000, addi(3, 7));
    enq_one(32'h3004, 32'hFFFF_FFFF);
    enq_one(32'h3008, addi(4, 9));
    checks++; if (illegal !== 1'b0) begin failures++; $display("[TB] FAIL illegal_first got=%b exp=0", illegal); end
    checks++; if (si.rd !== 5'd3) begin failures++; $display("[TB] FAIL illegal_first_rd got=%0d exp=3", si.rd); end
    bus.dec_ready_i = 1'b1;
    step();
    bus.dec_ready_i = 1'b0;
    checks++; if (illegal !== 1'b1) begin failures++; $display("[TB] FAIL illegal_head got=%b exp=1", illegal); end
    checks++; if (si.op !== C::I_ILLEGAL) begin failures++; $display("[TB] FAIL illegal_op got=%0d exp=%0d", si.op, C::I_ILLEGAL); end
    checks++; if (si.pc !== 32'h3004) begin failures++; $display("[TB] FAIL illegal_pc got=%h exp=3004", si.pc); end
    bus.dec_ready_i = 1'b1;
    step();
    bus.dec_ready_i = 1'b0;
    checks++; if (illegal !== 1'b0) begin failures++; $display("[TB] FAIL illegal_next got=%b exp=0", illegal); end
    checks++; if (si.imm !== 32'd9) begin failures++; $display("[TB] FAIL illegal_next_imm got=%h exp=9", si.imm); end
    bus.dec_ready_i = 1'b1;
    step();
    bus.dec_ready_i = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL illegal_empty got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    bus.dec_ready_i = 1'b0;
    enq_one(32'h4000, addi(1, 1));
    enq_one(32'h4004, addi(2, 2));
    enq_one(32'h4008, addi(3, 3));
    checks++; if (count !== 3'd3) begin failures++; $display("[TB] FAIL flush_pre_count got=%0d exp=3", count); end
    flush = 1'b1;
    bus.fetch_valid_i = 1'b1;
    bus.fetch_pc_i    = 32'h400C;
    bus.fetch_instr_i = addi(4, 4);
    bus.dec_ready_i   = 1'b1;
    #1;
    checks++; if (bus.fetch_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_ready got=%b exp=0", bus.fetch_ready_o); end
    @(negedge clk);
    flush = 1'b0;
    bus.fetch_valid_i = 1'b0;
    bus.dec_ready_i   = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL flush_count got=%0d exp=0", count); end
    checks++; if (bus.dec_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid got=%b exp=0", bus.dec_valid_o); end
    enq_one(32'h4100, addi(5, 5));
    checks++; if (count !== 3'd1) begin failures++; $display("[TB] FAIL flush_after_count got=%0d exp=1", count); end
    checks++; if (si.pc !== 32'h4100) begin failures++; $display("[TB] FAIL flush_after_pc got=%h exp=4100", si.pc); end
    bus.dec_ready_i = 1'b1;
    step();
    bus.dec_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.dec_ready_i = 1'b0;
    enq_one(32'h5000, addi(1, 1));
    enq_one(32'h5004, addi(2, 2));
    enq_one(32'h5008, addi(3, 3));
    checks++; if (count !== 3'd3) begin failures++; $display("[TB] FAIL rstmid_pre_count got=%0d exp=3", count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL rstmid_count got=%0d exp=0", count); end
    checks++; if (bus.dec_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_valid got=%b exp=0", bus.dec_valid_o); end
    checks++; if (bus.fetch_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_ready got=%b exp=0", bus.fetch_ready_o); end
    @(negedge clk);
    rst = 1'b0;
    enq_one(32'h5100, addi(6, 6));
    checks++; if (count !== 3'd1) begin failures++; $display("[TB] FAIL rstmid_after_count got=%0d exp=1", count); end
    checks++; if (si.pc !== 32'h5100) begin failures++; $display("[TB] FAIL rstmid_after_pc got=%h exp=5100", si.pc); end
    checks++; if (si.rd !== 5'd6) begin failures++; $display("[TB] FAIL rstmid_after_rd got=%0d exp=6", si.rd); end
    bus.dec_ready_i = 1'b1;
    step();
    bus.dec_ready_i = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL rstmid_empty got=%0d exp=0", count); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
